// File: rtl/timer_sched_ctrl.sv
// ---------------------------------------------------------------------------
// timer_sched_ctrl
//   Multi-channel alarm scheduler on the system bus. A free-running 64-bit
//   system counter is shared by N_CH compare channels. A single 64-bit
//   comparator is time-shared by a round-robin scanner that visits one channel
//   per cycle. A channel is either one-shot or periodic. When it fires, it sets
//   a pending bit. The OR of all pending bits drives the interrupt request.
//
//   Optional feature macro: TIMER_SCHED_CLEAR_ON_READ_EN
//     When defined, a read of CAUSE clears the pending bit of the channel it
//     reports, at the next edge. A same-cycle set of that bit still wins.
//
// Parameters
//   N_CH                 number of compare channels (1..8)
//
// Ports
//   clk_i                clock
//   rst_i                asynchronous active-high reset
//   req_i                bus request
//   write_enable_i       1 = write, 0 = read
//   addr_i[31:0]         byte address (word aligned)
//   write_data_i[31:0]   write data
//   read_data_o[31:0]    read data, combinational from addr_i
//   ready_o              mirrors req_i (zero wait states)
//   interrupt_request_o  OR of all pending bits
//
// Register map
//   0x00 CNT_LO  0x04 CNT_HI  0x08 PENDING (W1C)  0x0C CAUSE  0x10 SOFT_RST
//   0x40 + 0x10*k : +0 CMP_LO, +4 CMP_HI, +8 PERIOD, +C CTRL {PERIODIC, EN}
// ---------------------------------------------------------------------------
module timer_sched_ctrl #(
    parameter int unsigned N_CH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o,
    output logic        interrupt_request_o
);

    localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    // State
    logic [63:0]       cnt_q, cnt_d;
    logic [63:0]       cmp_q    [N_CH];
    logic [63:0]       cmp_d    [N_CH];
    logic [31:0]       period_q [N_CH];
    logic [31:0]       period_d [N_CH];
    logic [N_CH-1:0]   en_q, en_d;
    logic [N_CH-1:0]   per_q, per_d;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    // Address decode
    logic        wr_req;
    logic        glb_hit;
    logic [2:0]  glb_field;
    logic [3:0]  slot;
    logic        ch_region;
    logic [1:0]  ch_field;
    logic [N_CH-1:0] ch_hit;

    assign wr_req    = req_i && write_enable_i;
    assign glb_hit   = (addr_i[31:5] == 27'd0) && (addr_i[1:0] == 2'b00);
    assign glb_field = addr_i[4:2];
    assign ch_field  = addr_i[3:2];
    // Channel windows start at 0x40, so address nibble [7:4] = 4 is channel 0.
    assign slot      = addr_i[7:4] - 4'd4;
    assign ch_region = (addr_i[31:8] == 24'd0) && (addr_i[1:0] == 2'b00) &&
                       (addr_i[7:4] >= 4'd4) && (addr_i[7:4] <= 4'd11) &&
                       (32'(slot) < N_CH);

    always_comb begin
        ch_hit = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            ch_hit[k] = ch_region && (slot == 4'(k));
        end
    end

    logic pend_wr;
    logic soft_rst;
    assign pend_wr  = wr_req && glb_hit && (glb_field == 3'd2);
    assign soft_rst = wr_req && glb_hit && (glb_field == 3'd4);

    // CAUSE: lowest-indexed pending channel
    logic        cause_found;
    logic [2:0]  cause_idx;
    logic [31:0] cause_val;

    always_comb begin
        cause_found = 1'b0;
        cause_idx   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (pend_q[k] && !cause_found) begin
                cause_found = 1'b1;
                cause_idx   = 3'(k);
            end
        end
        cause_val = cause_found ? {29'd0, cause_idx} : '1;
    end

    // Scanner: only the channel under the pointer can fire this cycle
    logic [N_CH-1:0] fire_vec;

    always_comb begin
        fire_vec = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (ptr_q == PTR_W'(k)) begin
                fire_vec[k] = en_q[k] && !pend_q[k] && (cnt_q >= cmp_q[k]);
            end
        end
    end

    // Read mux
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (glb_hit) begin
            case (glb_field)
                3'd0:    rdata = cnt_q[31:0];
                3'd1:    rdata = cnt_q[63:32];
                3'd2:    rdata[N_CH-1:0] = pend_q;
                3'd3:    rdata = cause_val;
                default: rdata = '0;
            endcase
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (ch_hit[k]) begin
                    case (ch_field)
                        2'd0:    rdata = cmp_q[k][31:0];
                        2'd1:    rdata = cmp_q[k][63:32];
                        2'd2:    rdata = period_q[k];
                        default: rdata = {30'd0, per_q[k], en_q[k]};
                    endcase
                end
            end
        end
    end

    assign read_data_o         = (req_i && !rst_i) ? rdata : '0;
    assign ready_o             = req_i;
    assign interrupt_request_o = |pend_q;

    // Next-state. Ordering inside this block encodes the conflict rules:
    // pending clears come before fire sets (set wins); fire updates come
    // before bus field writes (bus wins per field); soft reset comes last.
    always_comb begin
        cnt_d    = cnt_q + 64'd1;
        ptr_d    = (ptr_q == PTR_W'(N_CH - 1)) ? '0 : ptr_q + PTR_W'(1);
        cmp_d    = cmp_q;
        period_d = period_q;
        en_d     = en_q;
        per_d    = per_q;
        pend_d   = pend_q;

        if (pend_wr) begin
            pend_d = pend_d & ~write_data_i[N_CH-1:0];
        end

`ifdef TIMER_SCHED_CLEAR_ON_READ_EN
        if (req_i && !write_enable_i && glb_hit && (glb_field == 3'd3) && cause_found) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (cause_idx == 3'(k)) begin
                    pend_d[k] = 1'b0;
                end
            end
        end
`else
`endif

        for (int unsigned k = 0; k < N_CH; k++) begin
            if (fire_vec[k]) begin
                pend_d[k] = 1'b1;
                if (per_q[k] && (period_q[k] != 32'd0)) begin
                    cmp_d[k] = cmp_q[k] + {32'd0, period_q[k]};
                end else begin
                    en_d[k] = 1'b0;
                end
            end
        end

        for (int unsigned k = 0; k < N_CH; k++) begin
            if (wr_req && ch_hit[k]) begin
                case (ch_field)
                    2'd0: cmp_d[k][31:0]  = write_data_i;
                    2'd1: cmp_d[k][63:32] = write_data_i;
                    2'd2: period_d[k]     = write_data_i;
                    default: begin
                        en_d[k]  = write_data_i[0];
                        per_d[k] = write_data_i[1];
                    end
                endcase
            end
        end

        if (soft_rst) begin
            cnt_d  = '0;
            ptr_d  = '0;
            en_d   = '0;
            per_d  = '0;
            pend_d = '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                cmp_d[k]    = '0;
                period_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            ptr_q  <= '0;
            en_q   <= '0;
            per_q  <= '0;
            pend_q <= '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                cmp_q[k]    <= '0;
                period_q[k] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            en_q   <= en_d;
            per_q  <= per_d;
            pend_q <= pend_d;
            for (int unsigned k = 0; k < N_CH; k++) begin
                cmp_q[k]    <= cmp_d[k];
                period_q[k] <= period_d[k];
            end
        end
    end

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_sched_ctrl
//   Directed bench for timer_sched_ctrl (N_CH = 4). Each read pushes its
//   hand-computed expected data (and optionally the expected interrupt
//   level) into a queue; a negedge monitor pops and compares whenever a
//   read is presented on the bus. Counter value k advances by one per
//   bus operation or tick; expected values below are derived from k, the
//   scan pointer (k mod 4 after any reset), and the register semantics.
// ---------------------------------------------------------------------------
module tb_timer_sched_ctrl;

    localparam int unsigned N_CH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    always #5 clk = ~clk;

    timer_sched_ctrl #(.N_CH(N_CH)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .req_i               (req),
        .write_enable_i      (we),
        .addr_i              (addr),
        .write_data_i        (wdata),
        .read_data_o         (rdata),
        .ready_o             (ready),
        .interrupt_request_o (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          chk_irq;
        logic        exp_irq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (req && !we) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: addr %h has no expected entry", addr);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (rdata !== mon_e.exp) begin
                    errors++;
                    $display("FAIL %s: read_data got %h expected %h", mon_e.name, rdata, mon_e.exp);
                end
                checks++;
                if (ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_ready: ready got %b expected 1", mon_e.name, ready);
                end
                if (mon_e.chk_irq) begin
                    checks++;
                    if (irq !== mon_e.exp_irq) begin
                        errors++;
                        $display("FAIL %s_irq: irq got %b expected %b", mon_e.name, irq, mon_e.exp_irq);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick(1);
        req   = 1'b0;
        we    = 1'b0;
    endtask

    task automatic bus_read(input string nm, input logic [31:0] a, input logic [31:0] e,
                            input bit ci = 1'b0, input logic ei = 1'b0);
        exp_t x;
        x.name    = nm;
        x.exp     = e;
        x.chk_irq = ci;
        x.exp_irq = ei;
        sb.push_back(x);
        req  = 1'b1;
        we   = 1'b0;
        addr = a;
        tick(1);
        req  = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;                                   // k = 0

        // Counter runs from reset
        tick(5);                                      // k = 5
        bus_read("cnt_lo", 32'h00, 32'd5, 1'b1, 1'b0);
        bus_read("cnt_hi", 32'h04, 32'd0);

        // Reset mid-run with pending = 0101
        bus_write(32'h40, 32'd20);
        bus_write(32'h4C, 32'd1);
        bus_write(32'h60, 32'd20);
        bus_write(32'h6C, 32'd1);                     // k = 11
        tick(89);                                     // k = 100
        bus_read("pend_pre_rst", 32'h08, 32'h5, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        bus_read("cnt_in_rst", 32'h00, 32'd0, 1'b1, 1'b0);
        bus_read("pend_in_rst", 32'h08, 32'd0, 1'b1, 1'b0);
        bus_read("cause_in_rst", 32'h0C, 32'd0, 1'b1, 1'b0);
        rst = 1'b0;                                   // k = 0
        bus_read("pend_post_rst", 32'h08, 32'd0, 1'b1, 1'b0);
        bus_read("cnt_post_rst", 32'h00, 32'd1);      // k = 2 after

        // One-shot channel 0, CMP = 50: scanned at k%4==0, fires at 52
        tick(8);                                      // k = 10
        bus_write(32'h40, 32'd50);
        bus_write(32'h4C, 32'd1);                     // k = 12
        tick(39);                                     // k = 51
        bus_read("oneshot_early", 32'h08, 32'd0, 1'b1, 1'b0);
        tick(2);                                      // k = 54
        bus_read("oneshot_pend", 32'h08, 32'h1, 1'b1, 1'b1);
        bus_read("oneshot_ctrl", 32'h4C, 32'd0);
        bus_read("oneshot_cause", 32'h0C, 32'd0);
        bus_write(32'h08, 32'h1);
        bus_read("oneshot_w1c", 32'h08, 32'd0, 1'b1, 1'b0);   // k = 59 after

        // Periodic channel 2: CMP=100, PERIOD=40, fires at 102, 142, 182
        bus_write(32'h60, 32'd100);
        bus_write(32'h68, 32'd40);
        bus_write(32'h6C, 32'd3);                     // k = 62
        tick(42);                                     // k = 104
        bus_read("per_pend1", 32'h08, 32'h4, 1'b1, 1'b1);
        bus_write(32'h08, 32'h4);
        bus_read("per_cmp1", 32'h60, 32'd140);        // k = 107 after
        tick(37);                                     // k = 144
        bus_read("per_pend2", 32'h08, 32'h4, 1'b1, 1'b1);
        bus_write(32'h08, 32'h4);
        bus_read("per_cmp2", 32'h60, 32'd180);
        tick(37);                                     // k = 184
        bus_read("per_pend3", 32'h08, 32'h4, 1'b1, 1'b1);
        bus_write(32'h08, 32'h4);
        bus_read("per_cmp3", 32'h60, 32'd220);
        bus_read("per_ctrl", 32'h6C, 32'd3);
        bus_write(32'h6C, 32'd0);                     // k = 189

        // Priority: channels 1 and 3 with CMP = 0
        bus_write(32'h5C, 32'd1);
        bus_write(32'h7C, 32'd1);                     // k = 191
        tick(4);                                      // k = 195
        bus_read("prio_pend", 32'h08, 32'hA, 1'b1, 1'b1);
        bus_read("prio_cause1", 32'h0C, 32'd1);
        bus_write(32'h08, 32'h2);
        bus_read("prio_cause3", 32'h0C, 32'd3);
        bus_write(32'h08, 32'h8);
        bus_read("prio_none", 32'h0C, 32'hFFFF_FFFF, 1'b1, 1'b0);  // k = 201 after

        // Set beats W1C: channel 0 fires at k = 220 while W1C bit0 is written
        bus_write(32'h40, 32'd220);
        bus_write(32'h4C, 32'd1);                     // k = 203
        tick(17);                                     // k = 220
        bus_write(32'h08, 32'h1);
        bus_read("set_wins", 32'h08, 32'h1, 1'b1, 1'b1);
        bus_write(32'h08, 32'h1);
        bus_read("set_cleared", 32'h08, 32'd0, 1'b1, 1'b0);
        bus_read("set_ctrl", 32'h4C, 32'd0);          // k = 225 after

        // Soft reset
        bus_write(32'h5C, 32'd1);                     // ch1 fires at 229
        tick(4);                                      // k = 230
        bus_read("srst_pre", 32'h08, 32'h2, 1'b1, 1'b1);
        bus_write(32'h10, 32'd0);                     // k = 0
        bus_read("srst_pend", 32'h08, 32'd0, 1'b1, 1'b0);
        bus_read("srst_cnt", 32'h00, 32'd1);
        bus_read("srst_ctrl", 32'h5C, 32'd0);         // k = 3 after

        // Unmapped / out-of-range channel
        bus_write(32'h80, 32'd5);
        bus_read("ch4_ignored", 32'h80, 32'd0);
        bus_read("unmapped_14", 32'h14, 32'd0);
        bus_read("unmapped_c0", 32'hC0, 32'd0);       // k = 7 after

        // Bus write to CMP_LO in the cycle ch1 fires (k = 13)
        bus_write(32'h50, 32'd10);
        bus_write(32'h58, 32'd5);
        bus_write(32'h5C, 32'd3);                     // k = 10
        tick(3);                                      // k = 13
        bus_write(32'h50, 32'd1000);
        bus_read("bus_wins_cmp", 32'h50, 32'd1000);
        bus_read("bus_wins_pend", 32'h08, 32'h2, 1'b1, 1'b1);
        bus_write(32'h5C, 32'd0);
        bus_write(32'h08, 32'h2);                     // k = 18

        // CAUSE read side effect
        bus_write(32'h4C, 32'd1);                     // ch0 fires at 20
        tick(3);                                      // k = 22
        bus_read("cor_cause", 32'h0C, 32'd0, 1'b1, 1'b1);
`ifdef TIMER_SCHED_CLEAR_ON_READ_EN
        bus_read("cor_pend", 32'h08, 32'd0, 1'b1, 1'b0);
`else
        bus_read("cor_pend", 32'h08, 32'h1, 1'b1, 1'b1);
`endif

        tick(2);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected reads outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
